// File: rtl/neureka_infeat_buffer_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : neureka_infeat_buffer_bist_ctrl
// Description : March C- BIST engine for the input-feature buffer SCM test
//               wrapper. It drives the wrapper BIST port (bist/csn/wen/addr/
//               data), compares the read data that returns on q_t_i one cycle
//               later, and reports done/pass/fail.
//
//               March C- sequence:
//                   E0 up w0 | E1 up r0,w1 | E2 up r1,w0 |
//                   E3 dn r0,w1 | E4 dn r1,w0 | E5 up r0
//
// Ports       : clk_i        clock
//               rst_ni       synchronous active-low reset
//               start_i      start pulse (accepted only in IDLE or DONE)
//               bist_o       BIST mode select to the wrapper
//               csn_t_o      chip select, active low
//               wen_t_o      0 = write, 1 = read
//               a_t_o        address
//               d_t_o        write data
//               q_t_i        read data (valid one cycle after a read)
//               busy_o       test in progress
//               done_o       test complete, held until next start
//               pass_o       done and no mismatch
//               fail_o       sticky mismatch flag
//               fail_addr_o  address of the first mismatch
//               fail_elem_o  March element of the first mismatch
//
// Options     : NEUREKA_BIST_FAIL_CAPTURE_EN - when defined, fail_addr_o and
//               fail_elem_o capture the first mismatch; otherwise both are
//               tied to zero and no capture registers exist.
//
// Revision    : 1.0 - initial release
// ============================================================================
module neureka_infeat_buffer_bist_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  bist_o,
    output logic                  csn_t_o,
    output logic                  wen_t_o,
    output logic [ADDR_WIDTH-1:0] a_t_o,
    output logic [DATA_WIDTH-1:0] d_t_o,
    input  logic [DATA_WIDTH-1:0] q_t_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] c_ones      = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_elem, w_elem_nxt;
    logic                    r_op, w_op_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;

    logic w_start;
    logic w_is_write;
    logic w_wr_ones;
    logic w_rd_ones;
    logic w_last_op;
    logic w_down;
    logic w_next_down;
    logic w_last_addr;

    // Compare pipeline: the expected pattern is always all-0 or all-1, so one
    // bit is enough to carry it alongside the valid flag.
    logic r_cmp_valid;
    logic r_cmp_ones;
    logic r_fail;
    logic w_mismatch;

    // Element decode. E0 and E5 have a single op; E1..E4 have a read (op 0)
    // followed by a write (op 1).
    always_comb begin
        w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_is_write  = (r_elem == 3'd0) || r_op;
        w_wr_ones   = r_op && ((r_elem == 3'd1) || (r_elem == 3'd3));
        w_rd_ones   = (r_elem == 3'd2) || (r_elem == 3'd4);
        w_last_op   = ((r_elem == 3'd0) || (r_elem == 3'd5)) ? 1'b1 : r_op;
        w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_next_down = (r_elem == 3'd2) || (r_elem == 3'd3);
        w_last_addr = w_down ? (r_addr == '0) : (r_addr == c_last_addr);
    end

    // Next-state and BIST port outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_op_nxt    = r_op;
        w_addr_nxt  = r_addr;
        bist_o      = 1'b0;
        busy_o      = 1'b0;
        csn_t_o     = 1'b1;
        wen_t_o     = 1'b1;
        a_t_o       = '0;
        d_t_o       = '0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_elem_nxt  = 3'd0;
                    w_op_nxt    = 1'b0;
                    w_addr_nxt  = '0;
                end
            end

            ST_RUN: begin
                bist_o  = 1'b1;
                busy_o  = 1'b1;
                csn_t_o = 1'b0;
                wen_t_o = ~w_is_write;
                a_t_o   = r_addr;
                d_t_o   = w_wr_ones ? c_ones : '0;

                if (!w_last_op) begin
                    w_op_nxt = 1'b1;
                end else begin
                    w_op_nxt = 1'b0;
                    if (w_last_addr) begin
                        if (r_elem == 3'd5) begin
                            w_state_nxt = ST_DRAIN;
                        end else begin
                            // Reload instead of wrapping so no out-of-range
                            // address ever reaches the port.
                            w_elem_nxt = r_elem + 3'd1;
                            w_addr_nxt = w_next_down ? c_last_addr : '0;
                        end
                    end else begin
                        w_addr_nxt = w_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
                    end
                end
            end

            ST_DRAIN: begin
                // Port idle for one cycle while the final read compares.
                bist_o      = 1'b1;
                busy_o      = 1'b1;
                w_state_nxt = ST_DONE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_elem  <= 3'd0;
            r_op    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
            r_op    <= w_op_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    assign w_mismatch = r_cmp_valid && (q_t_i != (r_cmp_ones ? c_ones : '0));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cmp_valid <= 1'b0;
            r_cmp_ones  <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_cmp_valid <= (r_state == ST_RUN) && !w_is_write;
            r_cmp_ones  <= w_rd_ones;
            if (w_start) begin
                r_fail <= 1'b0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
            end
        end
    end

`ifdef NEUREKA_BIST_FAIL_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [2:0]            r_cmp_elem;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_elem;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cmp_addr  <= '0;
            r_cmp_elem  <= 3'd0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            r_cmp_addr <= r_addr;
            r_cmp_elem <= r_elem;
            if (w_start) begin
                r_fail_addr <= '0;
                r_fail_elem <= 3'd0;
            end else if (w_mismatch && !r_fail) begin
                // Only the first mismatch of a run is recorded.
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
            end
        end
    end

    assign fail_addr_o = r_fail_addr;
    assign fail_elem_o = r_fail_elem;
`else
    assign fail_addr_o = '0;
    assign fail_elem_o = 3'd0;
`endif

    assign done_o = (r_state == ST_DONE);
    assign fail_o = r_fail;
    assign pass_o = done_o && !r_fail;

endmodule
`default_nettype wire

// File: tb/tb_neureka_infeat_buffer_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_neureka_infeat_buffer_bist_ctrl
// Description : Bench for the March C- BIST controller. An SCM model with an
//               optional stuck-at bit answers the BIST port. The expected op
//               stream and final verdict are derived from a textual March C-
//               description and queued at each start; a monitor pops and
//               compares them as the DUT presents ops and completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neureka_infeat_buffer_bist_ctrl;

    localparam int AW = 6;
    localparam int DW = 128;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          bist_o, csn_t_o, wen_t_o;
    logic [AW-1:0] a_t_o;
    logic [DW-1:0] d_t_o;
    logic [DW-1:0] q_t_i;
    logic          busy_o, done_o, pass_o, fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [2:0]    fail_elem_o;

    neureka_infeat_buffer_bist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .bist_o      (bist_o),
        .csn_t_o     (csn_t_o),
        .wen_t_o     (wen_t_o),
        .a_t_o       (a_t_o),
        .d_t_o       (d_t_o),
        .q_t_i       (q_t_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    typedef struct packed {
        logic          fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
    } res_t;

    op_t  exp_ops [$];
    res_t exp_res [$];

    string march      [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    bit    march_down [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    bit fault_en;
    int fault_addr;
    int fault_bit;
    bit fault_val;

`ifdef NEUREKA_BIST_FAIL_CAPTURE_EN
    localparam logic [8:0] c_word5_capture = {6'd5, 3'd1};
`else
    localparam logic [8:0] c_word5_capture = 9'd0;
`endif

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (fault_en && (a == fault_addr)) r[fault_bit] = fault_val;
        return r;
    endfunction

    // SCM behind the wrapper: one-cycle read latency, stuck bit on read path.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] q_reg;
    always @(posedge clk) begin
        if (!csn_t_o) begin
            if (!wen_t_o) mem[a_t_o] <= d_t_o;
            else          q_reg      <= faulty(mem[a_t_o], int'(a_t_o));
        end
    end
    assign q_t_i = q_reg;

    // Walk March C- from its textual description and queue the expected ops
    // and verdict for the run about to start.
    task automatic build_expected();
        logic [DW-1:0] mm [NW];
        logic [DW-1:0] pat;
        res_t          r;
        op_t           t;
        string         s;
        int            a;
        r = '0;
        for (int e = 0; e < 6; e++) begin
            s = march[e];
            for (int i = 0; i < NW; i++) begin
                a = march_down[e] ? (NW - 1 - i) : i;
                for (int o = 0; o < s.len() / 2; o++) begin
                    pat = (s[2*o+1] == "1") ? {DW{1'b1}} : {DW{1'b0}};
                    t.a = AW'(a);
                    if (s[2*o] == "w") begin
                        mm[a] = pat;
                        t.wen = 1'b0;
                        t.d   = pat;
                    end else begin
                        t.wen = 1'b1;
                        t.d   = '0;
                        if ((faulty(mm[a], a) != pat) && !r.fail) begin
                            r.fail = 1'b1;
                            r.addr = AW'(a);
                            r.elem = 3'(e);
                        end
                    end
                    exp_ops.push_back(t);
                end
            end
        end
`ifndef NEUREKA_BIST_FAIL_CAPTURE_EN
        r.addr = '0;
        r.elem = 3'd0;
`endif
        exp_res.push_back(r);
    endtask

    // Monitor: pop and compare on every port op and on each completion.
    int   run_ops;
    logic done_prev = 1'b0;
    op_t  mon_op;
    res_t mon_res;
    always @(negedge clk) begin
        if (!csn_t_o) begin
            run_ops++;
            if (exp_ops.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL op_unexpected: got addr %0d wen %0b required no op", a_t_o, wen_t_o);
            end else begin
                mon_op = exp_ops.pop_front();
                check("op", {wen_t_o, a_t_o, d_t_o, bist_o, busy_o},
                      {mon_op.wen, mon_op.a, mon_op.d, 2'b11});
            end
        end
        if (done_o && !done_prev) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got done_o=1 required no completion");
            end else begin
                mon_res = exp_res.pop_front();
                check("result_flags", {fail_o, pass_o}, {mon_res.fail, !mon_res.fail});
                check("fail_capture", {fail_addr_o, fail_elem_o}, {mon_res.addr, mon_res.elem});
            end
        end
        done_prev <= done_o;
    end

    task automatic run_bist(input int extra_start_at, input int reset_at);
        int n;
        bit seen;
        build_expected();
        run_ops = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        // {busy, bist, fail, done, csn}
        check("start_clears", {busy_o, bist_o, fail_o, done_o, csn_t_o}, 5'b11000);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            if (n == extra_start_at - 1) start_i = 1'b1;
            if (n == reset_at - 1)       rst_ni  = 1'b0;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            n++;
            if (!rst_ni) begin
                check("reset_release", {csn_t_o, bist_o, busy_o, done_o, fail_o}, 5'b10000);
                exp_ops.delete();
                exp_res.delete();
                rst_ni = 1'b1;
                return;
            end
            if (done_o) seen = 1'b1;
        end
        check("done_cycle", n + 1, 642);
        @(posedge clk);
        #1;
        check("ops_count", run_ops, 10 * NW);
        check("queues_empty", exp_ops.size() + exp_res.size(), 0);
        check("done_held", {done_o, busy_o, bist_o, csn_t_o}, 4'b1001);
    endtask

    initial begin
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        fault_en = 1'b0;
        fault_addr = 0;
        fault_bit  = 0;
        fault_val  = 1'b0;
        q_reg    = '0;
        for (int i = 0; i < NW; i++) mem[i] = {4{$urandom()}};

        repeat (3) @(posedge clk);
        #1;
        // {bist, csn, wen, busy, done, pass, fail, a, fail_addr, fail_elem}
        check("reset_ctrl", {bist_o, csn_t_o, wen_t_o, busy_o, done_o, pass_o, fail_o,
                             a_t_o, fail_addr_o, fail_elem_o},
              {7'b0110000, 6'd0, 6'd0, 3'd0});
        check("reset_data", d_t_o, '0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", {csn_t_o, busy_o, done_o}, 3'b100);

        // Fault-free run
        run_bist(0, 0);

        // Word 5 bit 0 stuck-at-1
        fault_en = 1'b1; fault_addr = 5; fault_bit = 0; fault_val = 1'b1;
        run_bist(0, 0);
        check("word5_stuck", {fail_o, pass_o, done_o, fail_addr_o, fail_elem_o},
              {3'b101, c_word5_capture});

        // Restart from DONE after the failing run, fault removed
        fault_en = 1'b0;
        run_bist(0, 0);

        // start pulse mid-RUN is ignored
        run_bist(100, 0);

        // Reset mid-test, then a full run
        run_bist(0, 200);
        run_bist(0, 0);

        // Randomised faults and idle gaps
        for (int k = 0; k < 4; k++) begin
            fault_en   = ($urandom_range(0, 3) != 0);
            fault_addr = int'($urandom_range(0, NW - 1));
            fault_bit  = int'($urandom_range(0, DW - 1));
            fault_val  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_bist(0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
